// File: rtl/chacha20_keystream_serializer.sv
// Splits 512-bit ChaCha20 keystream blocks into WORD_WIDTH-bit words on a valid/ready stream.
// A two-entry buffer (active + pending) lets the next block arrive while the current one drains.
module chacha20_keystream_serializer #(
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [511:0]           block_in,
  input  logic                   block_valid,
  output logic                   block_ready,
  output logic [WORD_WIDTH-1:0]  word_out,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic [COUNT_WIDTH-1:0] blocks_consumed
);

  localparam int unsigned BLOCK_WIDTH = 512;
  localparam int unsigned NUM_WORDS   = BLOCK_WIDTH / WORD_WIDTH;
  localparam int unsigned IDX_WIDTH   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

  // State is {active_valid, pending_valid}; 2'b01 is unreachable.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_DRAIN = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] block_t;

  logic [1:0]             state_q, state_d;
  logic [IDX_WIDTH-1:0]   word_idx_q, word_idx_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  block_t                 active_q, active_d;
  block_t                 pending_q, pending_d;

  logic active_valid;
  logic pending_valid;
  logic acc;
  logic take;
  logic last;

  assign active_valid = state_q[1];
  assign pending_valid = state_q[0];

  assign block_ready     = !pending_valid;
  assign word_valid      = active_valid;
  assign word_out        = active_valid ? active_q[word_idx_q] : '0;
  assign blocks_consumed = count_q;

  assign acc  = block_valid & block_ready;
  assign take = word_valid & word_ready;
  assign last = take & (word_idx_q == LAST_IDX);

  // Control state; clear overrides everything on the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      word_idx_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      count_q    <= count_d;
    end
  end

  // Block data carries no reset; validity lives in state_q.
  always_ff @(posedge clock) begin
    active_q  <= active_d;
    pending_q <= pending_d;
  end

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    active_d   = active_q;
    pending_d  = pending_q;

    if (last) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end

    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          active_d   = block_in;
          word_idx_d = '0;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last) begin
          word_idx_d = '0;
          // Reloading active on the final word keeps the stream gap-free.
          if (acc) begin
            active_d = block_in;
          end else begin
            state_d = ST_EMPTY;
          end
        end else begin
          if (take) begin
            word_idx_d = word_idx_q + IDX_WIDTH'(1);
          end
          if (acc) begin
            pending_d = block_in;
            state_d   = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (last) begin
          active_d   = pending_q;
          word_idx_d = '0;
          state_d    = ST_DRAIN;
        end else if (take) begin
          word_idx_d = word_idx_q + IDX_WIDTH'(1);
        end
      end
      default: begin
        state_d    = ST_EMPTY;
        word_idx_d = '0;
      end
    endcase

    if (clear) begin
      state_d    = ST_EMPTY;
      word_idx_d = '0;
      count_d    = '0;
    end
  end

endmodule

// File: tb/tb_chacha20_keystream_serializer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-of-blocks model.
module tb_chacha20_keystream_serializer;

  localparam int unsigned WW = 32;
  localparam int unsigned NW = 512 / WW;

  logic           clock;
  logic           reset;
  logic           clear;
  logic [511:0]   block_in;
  logic           block_valid;
  logic           block_ready;
  logic [WW-1:0]  word_out;
  logic           word_valid;
  logic           word_ready;
  logic [31:0]    blocks_consumed;

  chacha20_keystream_serializer #(.WORD_WIDTH(WW), .COUNT_WIDTH(32)) dut (
    .clock           (clock),
    .reset           (reset),
    .clear           (clear),
    .block_in        (block_in),
    .block_valid     (block_valid),
    .block_ready     (block_ready),
    .word_out        (word_out),
    .word_valid      (word_valid),
    .word_ready      (word_ready),
    .blocks_consumed (blocks_consumed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] blk_word(input logic [511:0] b, input int k);
    return b[k*WW +: WW];
  endfunction

  function automatic logic [511:0] make_block(input logic [31:0] base);
    logic [511:0] b;
    for (int k = 0; k < NW; k++) b[k*WW +: WW] = base + 32'(k);
    return b;
  endfunction

  // Model: a FIFO of at most two whole blocks plus a read index into the oldest.
  logic [511:0] mq[$];
  int           m_idx;
  logic [31:0]  m_cnt;
  bit           m_take;
  bit           m_acc;

  always @(posedge clock or negedge reset) begin
    if (!reset || clear) begin
      mq.delete();
      m_idx = 0;
      m_cnt = 0;
    end else begin
      m_take = (mq.size() > 0) && word_ready;
      m_acc  = block_valid && (mq.size() < 2);
      if (m_take) begin
        m_idx++;
        if (m_idx == NW) begin
          void'(mq.pop_front());
          m_idx = 0;
          m_cnt++;
        end
      end
      if (m_acc) mq.push_back(block_in);
    end
  end

  bit            chk_en = 0;
  logic [31:0]   taken[$];
  int            ready_low_cnt;
  logic          exp_valid;
  logic          exp_ready;
  logic [WW-1:0] exp_word;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      exp_valid = (mq.size() > 0);
      exp_ready = (mq.size() < 2);
      exp_word  = exp_valid ? blk_word(mq[0], m_idx) : '0;
      check("word_valid", 64'(word_valid), 64'(exp_valid));
      check("block_ready", 64'(block_ready), 64'(exp_ready));
      check("word_out", 64'(word_out), 64'(exp_word));
      check("blocks_consumed", 64'(blocks_consumed), 64'(m_cnt));
      if (word_valid && word_ready) taken.push_back(word_out);
      if (!block_ready) ready_low_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Offer a block and hold it until accepted; returns 2ns after the accepting edge.
  task automatic send_block(input logic [511:0] blk);
    bit ok;
    ok = 0;
    block_in    = blk;
    block_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (block_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clock);
    #2;
    block_valid = 1'b0;
    check("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic check_taken(input string nm, input int first, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      if (first + i < taken.size()) check(nm, 64'(taken[first+i]), 64'(base + 32'(i)));
      else check(nm, 64'hDEAD, 64'(base + 32'(i)));
    end
  endtask

  logic [511:0] rblk;

  initial begin
    reset       = 1'b0;
    clear       = 1'b0;
    block_in    = '0;
    block_valid = 1'b0;
    word_ready  = 1'b1;
    @(posedge clock);
    chk_en = 1;
    tick(2);
    reset = 1'b1;

    // Reset then idle
    tick(5);
    check("idle_valid", 64'(word_valid), 64'd0);
    check("idle_ready", 64'(block_ready), 64'd1);
    check("idle_count", 64'(blocks_consumed), 64'd0);

    // Single block drain
    taken.delete();
    send_block(make_block(32'h1000_0000));
    check("latency_valid", 64'(word_valid), 64'd1);
    check("latency_word0", 64'(word_out), 64'h1000_0000);
    tick(20);
    check("single_n", 64'(taken.size()), 64'd16);
    check_taken("single_seq", 0, 16, 32'h1000_0000);
    check("single_count", 64'(blocks_consumed), 64'd1);

    // Back-to-back blocks
    taken.delete();
    ready_low_cnt = 0;
    send_block(make_block(32'hA000_0000));
    send_block(make_block(32'hB000_0000));
    tick(40);
    check("b2b_n", 64'(taken.size()), 64'd32);
    check_taken("b2b_a", 0, 16, 32'hA000_0000);
    check_taken("b2b_b", 16, 16, 32'hB000_0000);
    check("b2b_full_cycles", 64'(ready_low_cnt), 64'd15);
    check("b2b_count", 64'(blocks_consumed), 64'd3);

    // Backpressure with ready pattern 1,0,0,1
    taken.delete();
    word_ready = 1'b0;
    send_block(make_block(32'h5500_0000));
    for (int i = 0; i < 80; i++) begin
      word_ready = (i % 4 == 0) || (i % 4 == 3);
      tick(1);
    end
    word_ready = 1'b1;
    tick(3);
    check("bp_n", 64'(taken.size()), 64'd16);
    check_taken("bp_seq", 0, 16, 32'h5500_0000);
    check("bp_count", 64'(blocks_consumed), 64'd4);

    // Last word taken on the same edge a new block is accepted
    taken.delete();
    ready_low_cnt = 0;
    send_block(make_block(32'hD000_0000));
    tick(15);
    block_in    = make_block(32'hC000_0000);
    block_valid = 1'b1;
    tick(1);
    block_valid = 1'b0;
    check("sim_c0_valid", 64'(word_valid), 64'd1);
    check("sim_c0_word", 64'(word_out), 64'hC000_0000);
    tick(25);
    check("sim_n", 64'(taken.size()), 64'd32);
    check_taken("sim_d", 0, 16, 32'hD000_0000);
    check_taken("sim_c", 16, 16, 32'hC000_0000);
    check("sim_never_full", 64'(ready_low_cnt), 64'd0);
    check("sim_count", 64'(blocks_consumed), 64'd6);

    // Asynchronous reset after word 5
    taken.delete();
    send_block(make_block(32'hE000_0000));
    tick(6);
    reset = 1'b0;
    #1;
    check("rst_async_valid", 64'(word_valid), 64'd0);
    check("rst_async_ready", 64'(block_ready), 64'd1);
    check("rst_async_count", 64'(blocks_consumed), 64'd0);
    #1;
    reset = 1'b1;
    tick(25);
    check("rst_n", 64'(taken.size()), 64'd6);
    check_taken("rst_seq", 0, 6, 32'hE000_0000);
    check("rst_count", 64'(blocks_consumed), 64'd0);

    // Synchronous clear after word 9
    taken.delete();
    send_block(make_block(32'h6000_0000));
    tick(20);
    check("clr_pre_count", 64'(blocks_consumed), 64'd1);
    send_block(make_block(32'hF000_0000));
    tick(10);
    clear      = 1'b1;
    word_ready = 1'b0;
    tick(1);
    clear = 1'b0;
    check("clr_valid", 64'(word_valid), 64'd0);
    check("clr_ready", 64'(block_ready), 64'd1);
    check("clr_count", 64'(blocks_consumed), 64'd0);
    word_ready = 1'b1;
    tick(25);
    check("clr_n", 64'(taken.size()), 64'd26);
    check_taken("clr_seq", 16, 10, 32'hF000_0000);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NW; k++) rblk[k*WW +: WW] = $urandom;
      block_in    = rblk;
      block_valid = ($urandom % 3) != 0;
      word_ready  = ($urandom % 4) != 0;
      clear       = ($urandom % 256) == 0;
      tick(1);
    end
    block_valid = 1'b0;
    clear       = 1'b0;
    word_ready  = 1'b1;
    tick(40);
    check("rand_drained", 64'(word_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
